data_access_ctrl: RTL and testbench

DATA_ACCESS_CTRL -- requirements
Module: data_access_ctrl

---
 rtl/data_access_ctrl.sv | 128 ++++++++++++
 tb/tb_data_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_access_ctrl.sv
// Data-side memory access controller: holds the MEM stage while one load/store crosses the bus.
// Optional access timeout with bus_err_o pulse is enabled by defining DACC_TIMEOUT_EN.
module data_access_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  input  logic        mem_device_i,
  input  logic        flush_i,
  input  logic        data_sram_ack_i,
  input  logic [31:0] data_sram_rdata_i,
  output logic        data_sram_en_o,
  output logic [3:0]  data_sram_wen_o,
  output logic [31:0] data_sram_addr_o,
  output logic [31:0] data_sram_wdata_o,
  output logic        stall_o,
  output logic [31:0] dm_o,
  output logic        dm_valid_o,
  output logic        dm_device_o,
  output logic [3:0]  dm_be_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, device_q, discard_q;
  logic        accept, in_access, in_done, timeout_hit, timed_out;

  assign accept    = (state == IDLE) & mem_req_i & ~flush_i;
  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);

`ifdef DACC_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       timed_out_q;

  // The edge that would take the counter to 255 ends the access instead.
  assign timeout_hit = in_access & ~data_sram_ack_i & (tmo_cnt == 8'd254);
  assign timed_out   = timed_out_q;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      tmo_cnt     <= 8'd0;
      timed_out_q <= 1'b0;
    end else begin
      if (accept)
        tmo_cnt <= 8'd0;
      else if (in_access && !data_sram_ack_i)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (accept)
        timed_out_q <= 1'b0;
      else if (timeout_hit)
        timed_out_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (data_sram_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once so the pipeline may change them while stalled.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      we_q      <= 1'b0;
      device_q  <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= mem_addr_i;
        wdata_q   <= mem_wdata_i;
        be_q      <= mem_be_i;
        we_q      <= mem_we_i;
        device_q  <= mem_device_i;
        discard_q <= 1'b0;
      end else if (in_access && flush_i) begin
        discard_q <= 1'b1;
      end
    end
  end

  // Raw read word goes to WB untouched; byte selection happens there.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      dm_o        <= 32'd0;
      dm_be_o     <= 4'd0;
      dm_device_o <= 1'b0;
    end else if (in_access && data_sram_ack_i && !we_q) begin
      dm_o        <= data_sram_rdata_i;
      dm_be_o     <= be_q;
      dm_device_o <= device_q;
    end
  end

  assign data_sram_en_o    = in_access;
  assign data_sram_wen_o   = (in_access && we_q) ? be_q : 4'b0000;
  assign data_sram_addr_o  = in_access ? addr_q : 32'd0;
  assign data_sram_wdata_o = in_access ? wdata_q : 32'd0;
  assign stall_o           = accept | in_access;
  assign dm_valid_o        = in_done & ~we_q & ~discard_q & ~flush_i & ~timed_out;
  assign bus_err_o         = in_done & timed_out;

endmodule

// File: tb/tb_data_access_ctrl.sv
// Self-checking bench for data_access_ctrl: directed vector table, hand sequences
// for reset/timeout corners, and random transactions checked against a transaction-level model.
module tb_data_access_ctrl;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        mem_req_i, mem_we_i, mem_device_i, flush_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        data_sram_ack_i;
  logic [31:0] data_sram_rdata_i;
  logic        data_sram_en_o;
  logic [3:0]  data_sram_wen_o;
  logic [31:0] data_sram_addr_o, data_sram_wdata_o;
  logic        stall_o;
  logic [31:0] dm_o;
  logic        dm_valid_o, dm_device_o;
  logic [3:0]  dm_be_o;
  logic        bus_err_o;

  data_access_ctrl dut (
    .cpu_clk_50M       (cpu_clk_50M),
    .cpu_rst           (cpu_rst),
    .mem_req_i         (mem_req_i),
    .mem_we_i          (mem_we_i),
    .mem_addr_i        (mem_addr_i),
    .mem_wdata_i       (mem_wdata_i),
    .mem_be_i          (mem_be_i),
    .mem_device_i      (mem_device_i),
    .flush_i           (flush_i),
    .data_sram_ack_i   (data_sram_ack_i),
    .data_sram_rdata_i (data_sram_rdata_i),
    .data_sram_en_o    (data_sram_en_o),
    .data_sram_wen_o   (data_sram_wen_o),
    .data_sram_addr_o  (data_sram_addr_o),
    .data_sram_wdata_o (data_sram_wdata_o),
    .stall_o           (stall_o),
    .dm_o              (dm_o),
    .dm_valid_o        (dm_valid_o),
    .dm_device_o       (dm_device_o),
    .dm_be_o           (dm_be_o),
    .bus_err_o         (bus_err_o)
  );

  initial begin
    cpu_clk_50M = 1'b0;
    forever #5 cpu_clk_50M = ~cpu_clk_50M;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        device;
    int          waits;
    int          flush_at;
    logic        flush_done;
    logic        req_in_done;
  } txn_t;

  typedef struct {
    int          stall_cnt;
    int          en_cnt;
    int          valid_cnt;
    int          err_cnt;
    int          bus_bad;
    logic [31:0] dm;
    logic [3:0]  dm_be;
    logic        dm_dev;
  } res_t;

  typedef struct {
    txn_t        t;
    int          exp_stall;
    int          exp_en;
    int          exp_valid;
    logic [31:0] exp_dm;
    logic [3:0]  exp_be;
    logic        exp_dev;
  } vec_t;

  int   checks;
  int   failures;
  res_t res;
  vec_t vecs[6];

  logic [31:0] last_dm;
  logic [3:0]  last_be;
  logic        last_dev;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " en"},       {31'd0, data_sram_en_o}, 32'd0);
    checkOutput({tag, " wen"},      {28'd0, data_sram_wen_o}, 32'd0);
    checkOutput({tag, " addr"},     data_sram_addr_o, 32'd0);
    checkOutput({tag, " wdata"},    data_sram_wdata_o, 32'd0);
    checkOutput({tag, " stall"},    {31'd0, stall_o}, 32'd0);
    checkOutput({tag, " dm"},       dm_o, 32'd0);
    checkOutput({tag, " dm_valid"}, {31'd0, dm_valid_o}, 32'd0);
    checkOutput({tag, " dm_dev"},   {31'd0, dm_device_o}, 32'd0);
    checkOutput({tag, " dm_be"},    {28'd0, dm_be_o}, 32'd0);
    checkOutput({tag, " bus_err"},  {31'd0, bus_err_o}, 32'd0);
  endtask

  task automatic sampleCycle();
    res.stall_cnt += int'(stall_o);
    res.en_cnt    += int'(data_sram_en_o);
    res.valid_cnt += int'(dm_valid_o);
    res.err_cnt   += int'(bus_err_o);
  endtask

  function automatic txn_t mkTxn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input logic device,
                                 input int waits, input int flush_at, input logic flush_done,
                                 input logic req_in_done);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.device = device;
    t.waits = waits; t.flush_at = flush_at; t.flush_done = flush_done; t.req_in_done = req_in_done;
    return t;
  endfunction

  // Drives one complete transaction: accept cycle, waits+1 bus cycles, then the done cycle.
  task automatic applyStimulus(input txn_t t);
    res = '{default: 0};
    mem_req_i = 1'b1; mem_we_i = t.we; mem_be_i = t.be; mem_addr_i = t.addr;
    mem_wdata_i = t.wdata; mem_device_i = t.device; flush_i = 1'b0;
    data_sram_ack_i = 1'b0; data_sram_rdata_i = $urandom;
    #4 sampleCycle();
    tick();
    for (int k = 0; k <= t.waits; k++) begin
      mem_req_i = 1'($urandom); mem_we_i = 1'($urandom); mem_be_i = 4'($urandom);
      mem_addr_i = $urandom; mem_wdata_i = $urandom; mem_device_i = 1'($urandom);
      flush_i = (k == t.flush_at);
      data_sram_ack_i = (k == t.waits);
      data_sram_rdata_i = (k == t.waits) ? t.rdata : $urandom;
      #4 sampleCycle();
      if (data_sram_en_o && ((data_sram_wen_o !== (t.we ? t.be : 4'b0000)) ||
          (data_sram_addr_o !== t.addr) || (data_sram_wdata_o !== t.wdata)))
        res.bus_bad++;
      tick();
    end
    mem_req_i = t.req_in_done; flush_i = t.flush_done;
    data_sram_ack_i = 1'($urandom); data_sram_rdata_i = $urandom;
    #4 sampleCycle();
    res.dm = dm_o; res.dm_be = dm_be_o; res.dm_dev = dm_device_o;
    tick();
    mem_req_i = 1'b0; flush_i = 1'b0; data_sram_ack_i = 1'b0;
  endtask

  task automatic doReset();
    cpu_rst = 1'b1;
    mem_req_i = 1'b0; flush_i = 1'b0; data_sram_ack_i = 1'b0;
    tick();
    tick();
    cpu_rst = 1'b0;
    last_dm = 32'd0; last_be = 4'd0; last_dev = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    cpu_rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
    mem_be_i = 4'd0; mem_device_i = 1'b0; flush_i = 1'b0;
    data_sram_ack_i = 1'b0; data_sram_rdata_i = 32'd0;

    vecs[0] = '{mkTxn(1'b0, 4'b1111, 32'h8000_1000, 32'h0, 32'h1122_3344, 1'b0, 0, -1, 1'b0, 1'b0),
                2, 1, 1, 32'h1122_3344, 4'b1111, 1'b0};
    vecs[1] = '{mkTxn(1'b1, 4'b0010, 32'h8000_2004, 32'h0000_AB00, 32'hDEAD_BEEF, 1'b0, 3, -1, 1'b0, 1'b0),
                5, 4, 0, 32'h1122_3344, 4'b1111, 1'b0};
    vecs[2] = '{mkTxn(1'b0, 4'b0011, 32'h1FAF_0000, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 1, 1'b0, 1'b0),
                4, 3, 0, 32'hCAFE_F00D, 4'b0011, 1'b1};
    vecs[3] = '{mkTxn(1'b0, 4'b1000, 32'h8000_3008, 32'h0, 32'h55AA_55AA, 1'b0, 1, -1, 1'b1, 1'b0),
                3, 2, 0, 32'h55AA_55AA, 4'b1000, 1'b0};
    vecs[4] = '{mkTxn(1'b0, 4'b0001, 32'h8000_400C, 32'h0, 32'h0000_00EF, 1'b0, 0, -1, 1'b0, 1'b1),
                2, 1, 1, 32'h0000_00EF, 4'b0001, 1'b0};
    vecs[5] = '{mkTxn(1'b0, 4'b1100, 32'h8000_5010, 32'h0, 32'hA5A5_0000, 1'b1, 5, -1, 1'b0, 1'b0),
                7, 6, 1, 32'hA5A5_0000, 4'b1100, 1'b1};

    doReset();
    #4 checkAllZero("reset");
    tick();

    // Directed table; each transaction starts in the idle cycle right after the previous done.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].t);
      checkOutput($sformatf("vec%0d stall_cycles", i), res.stall_cnt, vecs[i].exp_stall);
      checkOutput($sformatf("vec%0d en_cycles", i), res.en_cnt, vecs[i].exp_en);
      checkOutput($sformatf("vec%0d valid_pulses", i), res.valid_cnt, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d dm", i), res.dm, vecs[i].exp_dm);
      checkOutput($sformatf("vec%0d dm_be", i), {28'd0, res.dm_be}, {28'd0, vecs[i].exp_be});
      checkOutput($sformatf("vec%0d dm_dev", i), {31'd0, res.dm_dev}, {31'd0, vecs[i].exp_dev});
      checkOutput($sformatf("vec%0d bus_fields", i), res.bus_bad, 0);
      checkOutput($sformatf("vec%0d bus_err", i), res.err_cnt, 0);
    end

    // Reset in the middle of an access, then bus activity while idle must be ignored.
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'b1111; mem_addr_i = 32'h8000_6000;
    mem_device_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    #4 checkOutput("midrst en_before", {31'd0, data_sram_en_o}, 32'd1);
    tick();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    last_dm = 32'd0; last_be = 4'd0; last_dev = 1'b0;
    #4 checkAllZero("midrst");
    data_sram_ack_i = 1'b1; data_sram_rdata_i = 32'h7777_8888;
    tick();
    data_sram_ack_i = 1'b0;
    #4 checkOutput("idle_ack dm", dm_o, 32'd0);
    checkOutput("idle_ack en", {31'd0, data_sram_en_o}, 32'd0);
    tick();

    // Access that never receives an ack.
    res = '{default: 0};
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'b1111; mem_addr_i = 32'h8000_7000;
    tick();
    mem_req_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      data_sram_rdata_i = $urandom;
      #4 sampleCycle();
      tick();
    end
`ifdef DACC_TIMEOUT_EN
    checkOutput("timeout en_cycles", res.en_cnt, 255);
    checkOutput("timeout stall_cycles", res.stall_cnt, 255);
    checkOutput("timeout bus_err_pulses", res.err_cnt, 1);
    checkOutput("timeout valid_pulses", res.valid_cnt, 0);
`else
    checkOutput("noack stall_cycles", res.stall_cnt, 300);
    checkOutput("noack en_cycles", res.en_cnt, 300);
    checkOutput("noack bus_err_pulses", res.err_cnt, 0);
`endif
    doReset();

    // Random transactions against a transaction-level expectation.
    for (int n = 0; n < 40; n++) begin
      txn_t t;
      int   gap_bad;
      int   gap;
      logic [3:0] be_opts [7];
      int   exp_valid;
      be_opts = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      gap_bad = 0;
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) begin
        mem_req_i = 1'($urandom); flush_i = mem_req_i; mem_addr_i = $urandom;
        data_sram_ack_i = 1'($urandom); data_sram_rdata_i = $urandom;
        #4 if (stall_o || data_sram_en_o || dm_valid_o) gap_bad++;
        tick();
      end
      mem_req_i = 1'b0; flush_i = 1'b0; data_sram_ack_i = 1'b0;
      t.we = 1'($urandom);
      t.be = be_opts[$urandom_range(6, 0)];
      t.addr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.device = 1'($urandom);
      t.waits = int'($urandom_range(6, 0));
      t.flush_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(t.waits, 0)) : -1;
      t.flush_done = ($urandom_range(6, 0) == 0);
      t.req_in_done = 1'($urandom);
      applyStimulus(t);
      exp_valid = (!t.we && t.flush_at < 0 && !t.flush_done) ? 1 : 0;
      if (!t.we) begin
        last_dm = t.rdata; last_be = t.be; last_dev = t.device;
      end
      checkOutput($sformatf("rnd%0d gap_idle", n), gap_bad, 0);
      checkOutput($sformatf("rnd%0d stall_cycles", n), res.stall_cnt, t.waits + 2);
      checkOutput($sformatf("rnd%0d en_cycles", n), res.en_cnt, t.waits + 1);
      checkOutput($sformatf("rnd%0d valid_pulses", n), res.valid_cnt, exp_valid);
      checkOutput($sformatf("rnd%0d dm", n), res.dm, last_dm);
      checkOutput($sformatf("rnd%0d dm_be", n), {28'd0, res.dm_be}, {28'd0, last_be});
      checkOutput($sformatf("rnd%0d dm_dev", n), {31'd0, res.dm_dev}, {31'd0, last_dev});
      checkOutput($sformatf("rnd%0d bus_fields", n), res.bus_bad, 0);
      checkOutput($sformatf("rnd%0d bus_err", n), res.err_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
